// File: rtl/if_pc_sequencer_if.sv
// I-cache request/response port between the fetch PC owner and the I-cache.
// master drives the request; slave answers with hit/valid.
interface if_pc_sequencer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  ic_req_valid;
  logic [ADDR_WIDTH-1:0] ic_req_addr;
  logic                  ic_resp_valid;

  modport master (
    output ic_req_valid,
    output ic_req_addr,
    input  ic_resp_valid
  );

  modport slave (
    input  ic_req_valid,
    input  ic_req_addr,
    output ic_resp_valid
  );
endinterface

// File: rtl/if_pc_sequencer.sv
// Fetch-stage PC owner: applies stall/redirect, issues I-cache requests,
// tracks miss state and keeps saturating miss/redirect counters.
module if_pc_sequencer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_stall,
  input  logic                  load_pc_we,
  input  logic [ADDR_WIDTH-1:0] load_pc_new_pc,
  if_pc_sequencer_if.master     ic,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  misalign_err,
  output logic [CNT_WIDTH-1:0]  miss_cycles,
  output logic [CNT_WIDTH-1:0]  redirects
);

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    MISS_WAIT = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  active;
  logic                  redirect;
  logic                  miss;
  logic [ADDR_WIDTH-1:0] target;

  assign active   = (state != BOOT);
  assign redirect = active && load_pc_we;
  assign target   = {load_pc_new_pc[ADDR_WIDTH-1:2], 2'b00};
  assign miss     = (state == MISS_WAIT) ||
                    ((state == RUN) && !ic.ic_resp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (!ic.ic_resp_valid && !load_pc_we) begin
          state_nxt = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        if (ic.ic_resp_valid || load_pc_we) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // Request strobe depends only on the state register.
  always_comb begin
    ic.ic_req_valid = 1'b0;
    unique case (1'b1)
      (state == RUN):       ic.ic_req_valid = 1'b1;
      (state == MISS_WAIT): ic.ic_req_valid = 1'b1;
      default:              ic.ic_req_valid = 1'b0;
    endcase
  end

  assign ic.ic_req_addr = pc;
  assign if_pc          = pc;

  // Redirect wins over stall; low target bits are forced to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= target;
    end else if (active && !if_stall) begin
      pc <= pc + PC_STEP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_err <= 1'b0;
    end else if (redirect && (load_pc_new_pc[1:0] != 2'b00)) begin
      misalign_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirects <= '0;
    end else if (redirect && (redirects != CNT_MAX)) begin
      redirects <= redirects + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_cycles <= '0;
    end else if (miss && (miss_cycles != CNT_MAX)) begin
      miss_cycles <= miss_cycles + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_if_pc_sequencer.sv
// Directed bench for if_pc_sequencer: boot, miss, redirect, misalign,
// wrap, counter saturation and asynchronous reset mid-miss.
module tb_if_pc_sequencer;

  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          if_stall;
  logic          load_pc_we;
  logic [AW-1:0] load_pc_new_pc;
  logic [AW-1:0] if_pc;
  logic          misalign_err;
  logic [CW-1:0] miss_cycles;
  logic [CW-1:0] redirects;

  int checks;
  int failures;

  if_pc_sequencer_if #(.ADDR_WIDTH(AW)) ic ();

  if_pc_sequencer #(
    .ADDR_WIDTH(AW),
    .RESET_PC  (32'h0000_0000),
    .CNT_WIDTH (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_stall      (if_stall),
    .load_pc_we    (load_pc_we),
    .load_pc_new_pc(load_pc_new_pc),
    .ic            (ic.master),
    .if_pc         (if_pc),
    .misalign_err  (misalign_err),
    .miss_cycles   (miss_cycles),
    .redirects     (redirects)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc,
                         input logic vld, input logic mis,
                         input logic [31:0] mc, input logic [31:0] rd);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_addr"}, ic.ic_req_addr, pc);
    chk({tag, "_vld"}, {31'd0, ic.ic_req_valid}, {31'd0, vld});
    chk({tag, "_mis"}, {31'd0, misalign_err}, {31'd0, mis});
    chk({tag, "_mc"}, {28'd0, miss_cycles}, mc);
    chk({tag, "_rd"}, {28'd0, redirects}, rd);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    if_stall = 1'b0;
    load_pc_we = 1'b0;
    load_pc_new_pc = '0;
    ic.ic_resp_valid = 1'b1;
    step();
    step();
    chk_all("rst", 32'h0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b1;
    chk_all("boot0", 32'h0, 1'b0, 1'b0, 0, 0);
    step();
    chk_all("run0", 32'h0, 1'b1, 1'b0, 0, 0);
    step();
    chk("run4", if_pc, 32'h4);
    step();
    chk("run8", if_pc, 32'h8);
    step();
    step();
    chk("at10", if_pc, 32'h10);

    // Miss held for three cycles.
    ic.ic_resp_valid = 1'b0;
    if_stall = 1'b1;
    step();
    step();
    step();
    chk_all("miss3", 32'h10, 1'b1, 1'b0, 3, 0);
    ic.ic_resp_valid = 1'b1;
    if_stall = 1'b0;
    step();
    chk_all("missrel", 32'h14, 1'b1, 1'b0, 4, 0);
    step();
    chk_all("runagain", 32'h18, 1'b1, 1'b0, 4, 0);

    // Redirect overrides stall.
    if_stall = 1'b1;
    load_pc_we = 1'b1;
    load_pc_new_pc = 32'h400;
    step();
    chk_all("redir", 32'h400, 1'b1, 1'b0, 4, 1);
    load_pc_we = 1'b0;
    if_stall = 1'b0;
    step();
    chk_all("redir_run", 32'h404, 1'b1, 1'b0, 4, 1);

    // Misaligned redirect issued from MISS_WAIT.
    ic.ic_resp_valid = 1'b0;
    if_stall = 1'b1;
    step();
    chk("mw_enter", {28'd0, miss_cycles}, 32'd5);
    load_pc_we = 1'b1;
    load_pc_new_pc = 32'h203;
    step();
    chk_all("misal", 32'h200, 1'b1, 1'b1, 6, 2);
    load_pc_we = 1'b0;
    ic.ic_resp_valid = 1'b1;
    if_stall = 1'b0;
    step();
    chk_all("misal_run", 32'h204, 1'b1, 1'b1, 6, 2);
    for (int i = 0; i < 10; i++) step();
    chk_all("sticky", 32'h22C, 1'b1, 1'b1, 6, 2);

    // Wrap at the top of the address space.
    load_pc_we = 1'b1;
    load_pc_new_pc = 32'hFFFF_FFFC;
    step();
    chk("wrap_top", if_pc, 32'hFFFF_FFFC);
    load_pc_we = 1'b0;
    step();
    chk_all("wrap0", 32'h0, 1'b1, 1'b1, 6, 3);

    // Redirect counter saturation.
    load_pc_we = 1'b1;
    load_pc_new_pc = 32'h100;
    for (int i = 0; i < 12; i++) step();
    chk("rd_full", {28'd0, redirects}, 32'd15);
    for (int i = 0; i < 8; i++) step();
    chk("rd_sat", {28'd0, redirects}, 32'd15);
    load_pc_we = 1'b0;

    // Miss counter saturation.
    ic.ic_resp_valid = 1'b0;
    if_stall = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk_all("mc_sat", 32'h100, 1'b1, 1'b1, 15, 15);

    // Asynchronous reset between edges while in MISS_WAIT.
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("arst", 32'h0, 1'b0, 1'b0, 0, 0);
    ic.ic_resp_valid = 1'b1;
    if_stall = 1'b0;
    step();
    chk_all("arst_hold", 32'h0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b1;
    load_pc_we = 1'b1;
    load_pc_new_pc = 32'h83;
    chk_all("reboot", 32'h0, 1'b0, 1'b0, 0, 0);
    step();
    chk_all("boot_ign", 32'h0, 1'b1, 1'b0, 0, 0);
    load_pc_we = 1'b0;
    step();
    chk_all("reboot4", 32'h4, 1'b1, 1'b0, 0, 0);
    step();
    chk("reboot8", if_pc, 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
